// File: rtl/otter_muldiv_pkg.sv
// Shared types and helpers for the OTTER RV32M multiply/divide unit.
// Build option: OTTER_MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
package otter_muldiv_pkg;

   // The eight RV32M operations, encoded exactly as funct3
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // rs1 is interpreted as two's complement for these operations
   function automatic logic is_signed_a(input muldiv_op_t op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is interpreted as two's complement for these operations
   function automatic logic is_signed_b(input muldiv_op_t op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/otter_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// quotient/remainder show the values that the step taken this cycle produces,
// so the caller can capture the final answer on the last step's edge.
module otter_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr_q, dsr_d;

   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   // One restoring step: bring down the next dividend bit and trial-subtract
   always_comb begin
      shifted  = {rem_q, quo_q[WIDTH-1]};
      fits     = (shifted >= {1'b0, dsr_q});
      // When the divisor fits, the true difference is below the divisor,
      // so the low WIDTH bits of the subtraction are exact.
      diff     = shifted[WIDTH-1:0] - dsr_q;
      rem_step = fits ? diff : shifted[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], fits};
      quotient  = quo_step;
      remainder = rem_step;
   end

   // Next-state selection: load new operands or advance one step
   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dsr_d = dsr_q;
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dsr_d = divisor;
      end else if (step) begin
         rem_d = rem_step;
         quo_d = quo_step;
      end
   end

   // Divider state registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dsr_q <= dsr_d;
      end
   end

endmodule

// File: rtl/otter_muldiv.sv
// OTTER execute-stage RV32M unit: shift-add multiplier and restoring divider,
// one operation at a time, with a one-cycle done pulse.
// Build option: define OTTER_MULDIV_FAST_MUL_EN for single-cycle multiplies.
module otter_muldiv
   import otter_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_t    state_q, state_d;
   muldiv_op_t       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;          // product / quotient sign
   logic             rem_neg_q, rem_neg_d;  // remainder follows dividend sign
   logic [WIDTH-1:0] result_q, result_d;

   // Operand decode at acceptance
   muldiv_op_t       start_op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_by_zero, div_overflow;

   // Divider interface
   logic             div_load, div_step;
   logic [WIDTH-1:0] div_quo, div_rem;
   logic [WIDTH-1:0] div_quo_fix, div_rem_fix;

`ifdef OTTER_MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
`else
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;      // {partial high half, remaining multiplier}
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic [2*WIDTH-1:0] mul_fix;
`endif

   // Magnitudes and signs of the incoming operands
   always_comb begin
      start_op     = muldiv_op_t'(funct3);
      a_neg        = is_signed_a(start_op) & op_a[WIDTH-1];
      b_neg        = is_signed_b(start_op) & op_b[WIDTH-1];
      a_mag        = a_neg ? -op_a : op_a;
      b_mag        = b_neg ? -op_b : op_b;
      div_by_zero  = (op_b == '0);
      // Only DIV/REM (funct3[0]=0) can overflow
      div_overflow = ~funct3[0] & (op_a == MOST_NEG) & (op_b == '1);
   end

`ifdef OTTER_MULDIV_FAST_MUL_EN
   // Full-width product of sign- or zero-extended operands
   always_comb begin
      a_ext     = {{WIDTH{is_signed_a(start_op) & op_a[WIDTH-1]}}, op_a};
      b_ext     = {{WIDTH{is_signed_b(start_op) & op_b[WIDTH-1]}}, op_b};
      fast_prod = a_ext * b_ext;
   end
`else
   // One shift-add step on the magnitude product, plus the final sign fix
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      mul_step = {mul_sum, prod_q[WIDTH-1:1]};
      mul_fix  = neg_q ? -mul_step : mul_step;
   end
`endif

   // Sign fix of the divider's last step
   always_comb begin
      div_quo_fix = neg_q ? -div_quo : div_quo;
      div_rem_fix = rem_neg_q ? -div_rem : div_rem;
   end

   // Control FSM: next state, datapath loads and result capture
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      div_load  = 1'b0;
      div_step  = 1'b0;
`ifndef OTTER_MULDIV_FAST_MUL_EN
      mcand_d   = mcand_q;
      prod_d    = prod_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = start_op;
               cnt_d     = '0;
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               if (!funct3[2]) begin
`ifdef OTTER_MULDIV_FAST_MUL_EN
                  result_d = (start_op == OP_MUL) ? fast_prod[WIDTH-1:0]
                                                  : fast_prod[2*WIDTH-1:WIDTH];
                  state_d  = DONE;
`else
                  mcand_d = a_mag;
                  prod_d  = {{WIDTH{1'b0}}, b_mag};
                  state_d = MUL;
`endif
               end else if (div_by_zero) begin
                  // funct3[1] set means REM/REMU
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = DONE;
               end else if (div_overflow) begin
                  result_d = funct3[1] ? '0 : op_a;
                  state_d  = DONE;
               end else begin
                  div_load = 1'b1;
                  state_d  = DIV;
               end
            end
         end
         MUL: begin
`ifndef OTTER_MULDIV_FAST_MUL_EN
            prod_d = mul_step;
            if (cnt_q == CNT_LAST) begin
               result_d = (op_q == OP_MUL) ? mul_fix[WIDTH-1:0]
                                           : mul_fix[2*WIDTH-1:WIDTH];
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         DIV: begin
            div_step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               result_d = op_q[1] ? div_rem_fix : div_quo_fix;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers; reset aborts any operation in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         op_q      <= OP_MUL;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
`ifndef OTTER_MULDIV_FAST_MUL_EN
         mcand_q   <= '0;
         prod_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
`ifndef OTTER_MULDIV_FAST_MUL_EN
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
`endif
      end
   end

   otter_div_core #(
      .WIDTH (WIDTH)
   ) u_div_core (
      .CLK       (CLK),
      .RST       (RST),
      .load      (div_load),
      .step      (div_step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Directed and randomised checks of otter_muldiv with a result scoreboard.
module tb_otter_muldiv;

   localparam int W = 32;
`ifdef OTTER_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    funct3;
   logic [W-1:0]  op_a, op_b;
   logic          busy, done;
   logic [W-1:0]  result;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  sb_q[$];

   always #5 clk = ~clk;

   otter_muldiv #(.WIDTH(W)) dut (
      .CLK    (clk),
      .RST    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results from 64-bit arithmetic
   function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      int                 ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      p  = '0;
      case (f)
         3'b000: begin p = sa * sb; return p[31:0];  end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: if (b == 0) return '1; else if (a == 32'h8000_0000 && b == '1) return a; else return ia / ib;
         3'b101: if (b == 0) return '1; else return a / b;
         3'b110: if (b == 0) return a;  else if (a == 32'h8000_0000 && b == '1) return '0; else return ia % ib;
         default: if (b == 0) return a; else return a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!f[2]) return MUL_LAT;
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == '1) return 1;
      return DIV_LAT;
   endfunction

   // Issue one op, scramble operands after acceptance, check latency/busy/result.
   // With poke set, start is re-pulsed in cycle 5 and in the done cycle.
   task automatic issue(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat, input bit poke);
      int           cyc;
      bit           busy_ok;
      bit           seen;
      logic [W-1:0] got;
      @(negedge clk);
      funct3 = f; op_a = a; op_b = b; start = 1'b1;
      sb_q.push_back(exp);
      busy_ok = 1'b1; seen = 1'b0; cyc = 0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (poke && (cyc == 5 || cyc == lat)) begin
            start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd7;
         end else begin
            start = 1'b0; op_a = $urandom; op_b = $urandom;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) seen = 1'b1;
      end
      chk({tag, "_latency"}, W'(cyc), W'(lat));
      chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      got = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      chk({tag, "_result"}, result, got);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_held"}, result, got);
      $display("op %s f3=%b a=%h b=%h result=%h latency=%0d", tag, f, a, b, result, cyc);
      if (poke) begin
         busy_ok = 1'b1;
         repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_ok = 1'b0;
         end
         chk({tag, "_no_reissue"}, {31'd0, busy_ok}, 32'd1);
      end
   endtask

   initial begin
      logic [2:0] rf;
      logic [W-1:0] ra, rb;
      bit seen;

      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      rst = 1'b0;

      // Multiplies
      issue("mul_7x-3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
      issue("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
      issue("mulh_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b0);
      issue("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 1'b0);

      // Divides
      issue("div_-20_3",   3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, 1'b0);
      issue("rem_-20_3",   3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, 1'b0);
      issue("divu_20_3",   3'b101, 32'd20, 32'd3, 32'd6, DIV_LAT, 1'b0);
      issue("remu_20_3",   3'b111, 32'd20, 32'd3, 32'd2, DIV_LAT, 1'b0);

      // Special cases
      issue("divu_by0",    3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      issue("remu_by0",    3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b0);
      issue("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      issue("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

      // Reset during a divide at iteration 10
      @(negedge clk);
      funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_done", {31'd0, seen}, 32'd0);
      $display("op abort div reset at iteration 10, busy=%b done=%b result=%h", busy, done, result);
      issue("mul_3x4",     3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT, 1'b0);

      // start pulses while busy and in the done cycle are ignored
      issue("mul_2x3_poke", 3'b000, 32'd2, 32'd3, 32'd6, MUL_LAT, 1'b1);

      // Randomised ops against the reference model
      for (int i = 0; i < 12; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = 32'($urandom_range(0, 15));
         if (i == 6) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         issue($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb), lat_of(rf, ra, rb), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
